// File: rtl/stack_ctrl_pkg.sv
// Shared types for the stack-machine control unit: opcodes, ALU selects,
// FSM state encoding and the bundle of datapath strobes.
package stack_ctrl_pkg;

  localparam int OPCODE_W = 3;

  // Instruction opcodes as held in IR[7:5].
  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_NOT  = 3'b011,
    OP_PUSH = 3'b100,
    OP_POP  = 3'b101,
    OP_JMP  = 3'b110,
    OP_JZ   = 3'b111
  } opcode_e;

  // ALU function select; matches opcode[1:0] for the arithmetic group.
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_op_e;

  // FSM states. FETCH is all-zeros so a cleared register lands there.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_POPX   = 4'd2,
    S_POPY   = 4'd3,
    S_PUSHR  = 4'd4,
    S_PUSHM  = 4'd5,
    S_POPM   = 4'd6,
    S_JMP    = 4'd7,
    S_JZ     = 4'd8
  } state_e;

  // Every strobe the controller drives into the datapath.
  typedef struct packed {
    logic    ir_write;
    logic    pc_update;
    logic    pc_write;
    logic    adr_src;
    logic    mem_write;
    logic    stack_src;
    logic    push;
    logic    pop;
    logic    x_write;
    logic    y_write;
    alu_op_e alu_ctrl;
    logic    instr_done;
  } ctrl_t;

  // All strobes low, default mux selects (AdrSrc=0, StackSrc=0, ALU=ADD).
  localparam ctrl_t CTRL_IDLE = '0;

  // First execute state entered from DECODE for a given opcode.
  function automatic state_e decode_target(input opcode_e op);
    state_e target;
    case (op)
      OP_PUSH: target = S_PUSHM;
      OP_POP:  target = S_POPM;
      OP_JMP:  target = S_JMP;
      OP_JZ:   target = S_JZ;
      default: target = S_POPX;   // ADD, SUB, AND, NOT all start by popping X
    endcase
    return target;
  endfunction

  // ALU select for the arithmetic group is carried directly in the opcode.
  function automatic alu_op_e alu_op_of(input opcode_e op);
    return alu_op_e'(op[1:0]);
  endfunction

endpackage

// File: rtl/stack_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute controller for the 8-bit stack-machine
// datapath. One instruction in flight; 3 to 5 cycles per instruction.
// Outputs are decoded from the current state (plus the IR opcode), except
// the JZ PC load, which follows NorTop in the same cycle.
module stack_ctrl_fsm
  import stack_ctrl_pkg::*;
#(
  parameter int OP_W = OPCODE_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opCode,
  input  logic            NorTop,
  output logic            IRwrite,
  output logic            PCUpdate,
  output logic            PCwrite,
  output logic            AdrSrc,
  output logic            MemWrite,
  output logic            StackSrc,
  output logic            Push,
  output logic            Pop,
  output logic            Xwrite,
  output logic            Ywrite,
  output logic [1:0]      ALUControl,
  output logic            InstrDone,
  output logic [3:0]      CtrlState
);

  state_e  state_q;
  state_e  state_d;
  ctrl_t   ctrl;
  opcode_e op;

  assign op = opcode_e'(opCode);

  // State register; a synchronous reset returns the FSM to FETCH.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection; illegal encodings recover to FETCH.
  always_comb begin
    // NOTE: assigning a default before the case keeps this purely
    // combinational; a missed branch would otherwise infer a latch.
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = decode_target(op);
      S_POPX:   state_d = (op == OP_NOT) ? S_PUSHR : S_POPY;
      S_POPY:   state_d = S_PUSHR;
      S_PUSHR,
      S_PUSHM,
      S_POPM,
      S_JMP,
      S_JZ:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Strobe decode per state; reset and illegal states drive everything low
  // so an aborted instruction leaves no trailing push, write or jump.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          ctrl.ir_write  = 1'b1;
          ctrl.pc_update = 1'b1;
        end
        S_DECODE: begin
          ctrl = CTRL_IDLE;
        end
        S_POPX: begin
          ctrl.x_write = 1'b1;
          ctrl.pop     = 1'b1;
        end
        S_POPY: begin
          ctrl.y_write = 1'b1;
          ctrl.pop     = 1'b1;
        end
        S_PUSHR: begin
          ctrl.push       = 1'b1;
          ctrl.stack_src  = 1'b0;
          ctrl.alu_ctrl   = alu_op_of(op);
          ctrl.instr_done = 1'b1;
        end
        S_PUSHM: begin
          ctrl.adr_src    = 1'b1;
          ctrl.stack_src  = 1'b1;
          ctrl.push       = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_POPM: begin
          ctrl.adr_src    = 1'b1;
          ctrl.mem_write  = 1'b1;
          ctrl.pop        = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_JMP: begin
          ctrl.pc_write   = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_JZ: begin
          ctrl.pc_write   = NorTop;   // branch taken only when stack top is zero
          ctrl.instr_done = 1'b1;
        end
        default: begin
          ctrl = CTRL_IDLE;
        end
      endcase
    end
  end

  assign IRwrite    = ctrl.ir_write;
  assign PCUpdate   = ctrl.pc_update;
  assign PCwrite    = ctrl.pc_write;
  assign AdrSrc     = ctrl.adr_src;
  assign MemWrite   = ctrl.mem_write;
  assign StackSrc   = ctrl.stack_src;
  assign Push       = ctrl.push;
  assign Pop        = ctrl.pop;
  assign Xwrite     = ctrl.x_write;
  assign Ywrite     = ctrl.y_write;
  assign ALUControl = ctrl.alu_ctrl;
  assign InstrDone  = ctrl.instr_done;
  // Debug view reads FETCH while reset is held, even before the first edge.
  assign CtrlState  = rst ? S_FETCH : state_q;

endmodule

// File: tb/tb_stack_ctrl_fsm.sv
// Self-checking bench for stack_ctrl_fsm. A per-instruction reference model
// lists, cycle by cycle, the state and strobes each opcode should produce;
// directed cases come first, then randomized instruction streams with
// occasional mid-instruction resets.
module tb_stack_ctrl_fsm;
  import stack_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opCode;
  logic       NorTop;
  logic       IRwrite, PCUpdate, PCwrite, AdrSrc, MemWrite, StackSrc;
  logic       Push, Pop, Xwrite, Ywrite, InstrDone;
  logic [1:0] ALUControl;
  logic [3:0] CtrlState;

  stack_ctrl_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .opCode     (opCode),
    .NorTop     (NorTop),
    .IRwrite    (IRwrite),
    .PCUpdate   (PCUpdate),
    .PCwrite    (PCwrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .StackSrc   (StackSrc),
    .Push       (Push),
    .Pop        (Pop),
    .Xwrite     (Xwrite),
    .Ywrite     (Ywrite),
    .ALUControl (ALUControl),
    .InstrDone  (InstrDone),
    .CtrlState  (CtrlState)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe vector layout:
  // {IRwrite,PCUpdate,PCwrite,AdrSrc,MemWrite,StackSrc,Push,Pop,Xwrite,Ywrite,ALU[1:0],InstrDone}
  localparam logic [12:0] B_IRW  = 13'b1_0000_0000_0000;
  localparam logic [12:0] B_PCU  = 13'b0_1000_0000_0000;
  localparam logic [12:0] B_PCW  = 13'b0_0100_0000_0000;
  localparam logic [12:0] B_ADR  = 13'b0_0010_0000_0000;
  localparam logic [12:0] B_MW   = 13'b0_0001_0000_0000;
  localparam logic [12:0] B_SS   = 13'b0_0000_1000_0000;
  localparam logic [12:0] B_PUSH = 13'b0_0000_0100_0000;
  localparam logic [12:0] B_POP  = 13'b0_0000_0010_0000;
  localparam logic [12:0] B_XW   = 13'b0_0000_0001_0000;
  localparam logic [12:0] B_YW   = 13'b0_0000_0000_1000;
  localparam logic [12:0] B_DONE = 13'b0_0000_0000_0001;

  typedef struct {
    state_e      st;
    logic [12:0] sig;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [12:0] alu_bits(input logic [1:0] a);
    logic [12:0] v;
    v = 13'd0;
    v[2:1] = a;
    return v;
  endfunction

  function automatic void add_cycle(input state_e st, input logic [12:0] sig);
    exp_t e;
    e.st  = st;
    e.sig = sig;
    exp_q.push_back(e);
  endfunction

  // Reference: the full cycle list for one instruction, straight from the
  // instruction-level description (fetch, decode, then opcode-specific work).
  function automatic void build(input logic [2:0] op, input logic nt);
    exp_q.delete();
    add_cycle(S_FETCH, B_IRW | B_PCU);
    add_cycle(S_DECODE, 13'd0);
    if (op < 3'd4) begin
      add_cycle(S_POPX, B_XW | B_POP);
      if (op != 3'd3) add_cycle(S_POPY, B_YW | B_POP);
      add_cycle(S_PUSHR, B_PUSH | alu_bits(op[1:0]) | B_DONE);
    end else if (op == 3'd4) begin
      add_cycle(S_PUSHM, B_ADR | B_SS | B_PUSH | B_DONE);
    end else if (op == 3'd5) begin
      add_cycle(S_POPM, B_ADR | B_MW | B_POP | B_DONE);
    end else if (op == 3'd6) begin
      add_cycle(S_JMP, B_PCW | B_DONE);
    end else begin
      add_cycle(S_JZ, (nt ? B_PCW : 13'd0) | B_DONE);
    end
  endfunction

  function automatic logic [12:0] actual_sig();
    return {IRwrite, PCUpdate, PCwrite, AdrSrc, MemWrite, StackSrc,
            Push, Pop, Xwrite, Ywrite, ALUControl, InstrDone};
  endfunction

  // Run one instruction against the model. abort_at >= 0 raises rst in that
  // cycle: outputs must be all low and the next instruction starts at FETCH.
  task automatic run_instr(input string name, input logic [2:0] op, input logic nt,
                           input int abort_at);
    int len;
    build(op, nt);
    len = exp_q.size();
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      opCode = op;
      NorTop = nt;
      rst    = (i == abort_at);
      #1;
      if (rst) begin
        check($sformatf("%s[%0d].rst_sig", name, i), 32'(actual_sig()), 32'd0);
        check($sformatf("%s[%0d].rst_state", name, i), 32'(CtrlState), 32'(S_FETCH));
        break;
      end
      check($sformatf("%s[%0d].sig", name, i), 32'(actual_sig()), 32'(exp_q[i].sig));
      check($sformatf("%s[%0d].state", name, i), 32'(CtrlState), 32'(exp_q[i].st));
      check($sformatf("%s[%0d].push_pop", name, i), 32'(Push & Pop), 32'd0);
      check($sformatf("%s[%0d].mw_adr", name, i), 32'(MemWrite & ~AdrSrc), 32'd0);
    end
  endtask

  initial begin
    logic [2:0] rop;
    logic       rnt;
    int         rabort;

    // Reset held for two cycles with a JZ opcode and NorTop high.
    rst    = 1'b1;
    opCode = 3'b111;
    NorTop = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("reset[%0d].sig", i), 32'(actual_sig()), 32'd0);
      check($sformatf("reset[%0d].state", i), 32'(CtrlState), 32'(S_FETCH));
    end

    // Directed instructions.
    run_instr("sub",    3'b001, 1'b0, -1);
    run_instr("not",    3'b011, 1'b1, -1);
    run_instr("push",   3'b100, 1'b0, -1);
    run_instr("pop",    3'b101, 1'b1, -1);
    run_instr("jz_nt0", 3'b111, 1'b0, -1);
    run_instr("jz_nt1", 3'b111, 1'b1, -1);
    run_instr("jmp",    3'b110, 1'b0, -1);
    run_instr("and",    3'b010, 1'b1, -1);
    run_instr("add_rst_popy", 3'b000, 1'b0, 3);
    run_instr("after_rst", 3'b100, 1'b1, -1);

    // Randomized instruction stream with occasional aborts.
    for (int n = 0; n < 400; n++) begin
      rop    = 3'($urandom_range(0, 7));
      rnt    = 1'($urandom_range(0, 1));
      rabort = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr($sformatf("rnd%0d_op%0d", n, rop), rop, rnt, rabort);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
